sdram_patch_loader: RTL and testbench
=====================================

Name: sdram_patch_loader

Overview:
- Wishbone master that sits between the convnet core and the SDRAM Wishbone slave.
- Fetches one K×K window of pixels from SDRAM and packs it into the flat bus that drives the core's PATCHES input.
- Also writes single 32-bit result words back to SDRAM.
- Uses classic single-transfer cycles: one word per cyc_i assertion, with cyc_i dropped between words.

Parameters:
- PIX_W, 16, pixel width; each pixel is data_o[PIX_W-1:0] of one SDRAM word.
- K, 3, window side; K*K words are fetched per patch.
- TIMEOUT, 255, maximum cycles cyc_i may wait for sdram_ack before the loader aborts.

Ports:
- CLK  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_fetch  in  1  one-cycle request to fetch a window; sampled only in IDLE.
- base_addr  in  32  word address of the window's top-left pixel.
- stride  in  32  word distance between image rows.
- start_store  in  1  one-cycle request to write one word; sampled only in IDLE.
- store_addr  in  32  write address.
- store_data  in  32  write data.
- busy  out  1  high from the cycle after an accepted start until the done/err pulse.
- patch_valid  out  1  one-cycle pulse when patches is complete.
- patches  out  PIX_W*K*K  pixel (r,c) at bits [PIX_W*(r*K+c) +: PIX_W]; held until the next fetch completes.
- store_done  out  1  one-cycle pulse when the write is acknowledged.
- err  out  1  one-cycle pulse on timeout.
- data_o  in  32  slave read data.
- stall_o  in  1  slave stall.
- sdram_ack  in  1  slave acknowledge.
- stb_i, we_i, cyc_i  out  1 each  Wishbone strobe, write enable and cycle.
- sel_i  out  4  byte selects; always 4'b1111 during a cycle.
- addr_i  out  32  transfer address.
- data_i  out  32  transfer write data.

Behaviour:
- Reset values: all outputs 0, patches 0, state IDLE. Reset asserted mid-transfer drops cyc_i/stb_i at that edge; the partial patch is discarded with no pulse.
- States:
  - IDLE → FETCH_REQ on start_fetch.
  - IDLE → STORE_REQ on start_store.
  - If both starts arrive in the same cycle, fetch wins and the store is dropped. Starts seen while busy are ignored, not queued.
- FETCH_REQ / STORE_REQ:
  - cyc_i=stb_i=1 together; addr_i and data_i/we_i stay stable until ack.
  - stb_i drops in any cycle stall_o=1; cyc_i stays high.
  - On a sampled sdram_ack=1, read data_o[PIX_W-1:0] into the current slot, then go to GAP with cyc_i=stb_i=0 at that edge.
- GAP:
  - Exactly one cycle with cyc_i=0; this is needed because the slave holds ack while cyc_i is high.
  - Then go to the next FETCH_REQ, or finish.
- Addresses:
  - Fetch order is row-major, r=0..K-1, c=0..K-1.
  - addr = row_base + c, where row_base starts at base_addr and gains stride after each row.
  - Use accumulators, no multiplier; all sums wrap mod 2^32.
- Completion:
  - After the K*K-th ack, go to IDLE; in that same cycle the full patch is already on patches and patch_valid=1.
  - A store goes STORE_REQ (we_i=1) → GAP → IDLE with store_done=1 on the GAP→IDLE edge.
- Timeout:
  - A per-transfer counter is cleared when cyc_i rises.
  - If it reaches TIMEOUT with no ack: drop cyc_i/stb_i, pulse err, return to IDLE, leave patches unchanged, and emit no patch_valid/store_done.
- busy covers from the cycle after an accepted start to the cycle before the done/err pulse; it is low in the pulse cycle, so a new start is accepted then.
- Any ack seen outside a REQ state is ignored.

Decomposition:
- Package convnet_pkg holds:
  - PIX_W and K defaults;
  - the state enum (IDLE, FETCH_REQ, STORE_REQ, GAP);
  - the WB_SEL_ALL=4'b1111 constant.
- Sub-module wb_single_xfer runs one Wishbone transfer: request/ack/timeout handshake and the GAP cycle, reporting done/err/rdata.
- The top handles sequencing, address accumulation and patch packing.

Test Plan:
- Fetch, happy path: preload sdram[a]=a; base=10, stride=8 → addresses 10,11,12,18,19,20,26,27,28; patches[15:0]=10 and [143:128]=28; exactly one patch_valid; cyc_i is low for one cycle between each of the 9 transfers.
- Store: store_addr=5, store_data=32'hDEADBEEF → sdram[5]=DEADBEEF; store_done pulses once; we_i=1 only while cyc_i=1.
- Simultaneous starts: start_fetch=start_store=1 in IDLE → only the fetch runs; no write occurs; sdram unchanged.
- Timeout: slave never acks → cyc_i drops after exactly TIMEOUT cycles; err pulses once; patches keep the previous value.
- Reset mid-fetch: rst=1 during the 4th transfer → cyc_i=stb_i=0 next cycle; busy=0; no patch_valid; a new fetch of base=0 then completes correctly.
- Wrap-around: base=32'hFFFF_FFFE, stride=1 → addresses FFFFFFFE, FFFFFFFF, 0, FFFFFFFF, 0, 1, 0, 1, 2 in that order.

Source files
------------

// File: rtl/convnet_pkg.sv
// rtl/convnet_pkg.sv - shared defaults, bus constants and transfer state encoding
package convnet_pkg;

  localparam int CONV_PIX_W = 16;
  localparam int CONV_K     = 3;

  localparam logic [3:0] WB_SEL_ALL = 4'b1111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_REQ = 2'd1,
    STORE_REQ = 2'd2,
    GAP       = 2'd3
  } xfer_state_t;

endpackage

// File: rtl/wb_single_xfer.sv
// rtl/wb_single_xfer.sv - one classic Wishbone transfer with timeout and trailing idle cycle
module wb_single_xfer
  import convnet_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_we,
  input  logic        i_more,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_stall,
  input  logic        i_ack,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic [3:0]  o_sel,
  output logic [31:0] o_adr,
  output logic [31:0] o_dat,
  output xfer_state_t o_state,
  output logic        o_acked,
  output logic        o_fin,
  output logic        o_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  xfer_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_fin;
  logic          r_err;
  logic          w_req;

  assign w_req   = (r_state == FETCH_REQ) || (r_state == STORE_REQ);
  assign o_cyc   = w_req;
  assign o_stb   = w_req & ~i_stall;
  assign o_we    = (r_state == STORE_REQ);
  assign o_sel   = w_req ? WB_SEL_ALL : 4'b0000;
  assign o_adr   = w_req ? i_addr : 32'd0;
  assign o_dat   = (r_state == STORE_REQ) ? i_wdata : 32'd0;
  assign o_state = r_state;
  assign o_acked = w_req & i_ack;
  assign o_fin   = r_fin;
  assign o_err   = r_err;

  // GAP keeps cyc low for one cycle because the slave holds ack while cyc is high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= i_we ? STORE_REQ : FETCH_REQ;
            r_cnt   <= '0;
          end
        end
        FETCH_REQ, STORE_REQ: begin
          if (i_ack) begin
            r_state <= GAP;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (i_more) begin
            r_state <= FETCH_REQ;
            r_cnt   <= '0;
          end else begin
            r_state <= IDLE;
            r_fin   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sdram_patch_loader.sv
// rtl/sdram_patch_loader.sv - fetches a KxK pixel window over Wishbone and stores single result words
module sdram_patch_loader
  import convnet_pkg::*;
#(
  parameter int PIX_W   = CONV_PIX_W,
  parameter int K       = CONV_K,
  parameter int TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   start_fetch,
  input  logic [31:0]            base_addr,
  input  logic [31:0]            stride,
  input  logic                   start_store,
  input  logic [31:0]            store_addr,
  input  logic [31:0]            store_data,
  output logic                   busy,
  output logic                   patch_valid,
  output logic [PIX_W*K*K-1:0]   patches,
  output logic                   store_done,
  output logic                   err,
  input  logic [31:0]            data_o,
  input  logic                   stall_o,
  input  logic                   sdram_ack,
  output logic                   stb_i,
  output logic                   we_i,
  output logic                   cyc_i,
  output logic [3:0]             sel_i,
  output logic [31:0]            addr_i,
  output logic [31:0]            data_i
);

  localparam int NPIX = K * K;
  localparam int IW   = $clog2(NPIX + 1);
  localparam int CWID = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0]   IDX_END  = IW'(NPIX);
  localparam logic [CWID-1:0] COL_LAST = CWID'(K - 1);

  xfer_state_t w_state;
  logic w_idle, w_accept_f, w_accept_s, w_more, w_acked, w_fin, w_err;
  logic w_unused_hi;

  logic                  r_fetching;
  logic [IW-1:0]         r_idx;
  logic [CWID-1:0]       r_col;
  logic [31:0]           r_row_base;
  logic [31:0]           r_stride;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [PIX_W*NPIX-1:0] r_work;
  logic [PIX_W*NPIX-1:0] r_patches;

  assign w_idle      = (w_state == IDLE);
  assign w_accept_f  = w_idle & start_fetch;
  assign w_accept_s  = w_idle & start_store & ~start_fetch;
  assign w_more      = r_fetching && (r_idx != IDX_END);
  assign w_unused_hi = ^data_o;

  assign busy        = ~w_idle;
  assign patch_valid = w_fin & r_fetching;
  assign store_done  = w_fin & ~r_fetching;
  assign err         = w_err;
  assign patches     = r_patches;

  wb_single_xfer #(
    .TIMEOUT(TIMEOUT)
  ) u_xfer (
    .i_clk  (CLK),
    .i_rst  (rst),
    .i_start(w_accept_f | w_accept_s),
    .i_we   (~start_fetch),
    .i_more (w_more),
    .i_addr (r_addr),
    .i_wdata(r_wdata),
    .i_stall(stall_o),
    .i_ack  (sdram_ack),
    .o_cyc  (cyc_i),
    .o_stb  (stb_i),
    .o_we   (we_i),
    .o_sel  (sel_i),
    .o_adr  (addr_i),
    .o_dat  (data_i),
    .o_state(w_state),
    .o_acked(w_acked),
    .o_fin  (w_fin),
    .o_err  (w_err)
  );

  // Pixels land in a working buffer; patches only changes when a whole window has arrived
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_fetching <= 1'b0;
      r_idx      <= '0;
      r_col      <= '0;
      r_row_base <= '0;
      r_stride   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_work     <= '0;
      r_patches  <= '0;
    end else begin
      if (w_accept_f) begin
        r_fetching <= 1'b1;
        r_idx      <= '0;
        r_col      <= '0;
        r_row_base <= base_addr;
        r_stride   <= stride;
        r_addr     <= base_addr;
      end else if (w_accept_s) begin
        r_fetching <= 1'b0;
        r_addr     <= store_addr;
        r_wdata    <= store_data;
      end

      if (w_acked && r_fetching) begin
        for (int i = 0; i < NPIX; i++) begin
          if (r_idx == IW'(i)) r_work[i*PIX_W +: PIX_W] <= data_o[PIX_W-1:0];
        end
        r_idx <= r_idx + 1'b1;
        if (r_col == COL_LAST) begin
          r_col      <= '0;
          r_row_base <= r_row_base + r_stride;
          r_addr     <= r_row_base + r_stride;
        end else begin
          r_col  <= r_col + 1'b1;
          r_addr <= r_addr + 32'd1;
        end
      end

      if ((w_state == GAP) && !w_more && r_fetching) r_patches <= r_work;
    end
  end

endmodule

// File: tb/tb_sdram_patch_loader.sv
// tb/tb_sdram_patch_loader.sv - self-checking bench for sdram_patch_loader
module tb_sdram_patch_loader;

  localparam int PIX_W = 16;
  localparam int K     = 3;
  localparam int TO    = 255;

  logic CLK = 1'b0, rst = 1'b1;
  logic start_fetch = 1'b0, start_store = 1'b0;
  logic [31:0] base_addr = '0, stride = '0, store_addr = '0, store_data = '0;
  logic [31:0] data_o = '0;
  logic stall_o = 1'b0, sdram_ack = 1'b0;
  logic busy, patch_valid, store_done, err, stb_i, we_i, cyc_i;
  logic [3:0] sel_i;
  logic [31:0] addr_i, data_i;
  logic [PIX_W*K*K-1:0] patches;

  always #5 CLK = ~CLK;

  sdram_patch_loader #(.PIX_W(PIX_W), .K(K), .TIMEOUT(TO)) dut (
    .CLK(CLK), .rst(rst), .start_fetch(start_fetch), .base_addr(base_addr), .stride(stride),
    .start_store(start_store), .store_addr(store_addr), .store_data(store_data),
    .busy(busy), .patch_valid(patch_valid), .patches(patches), .store_done(store_done), .err(err),
    .data_o(data_o), .stall_o(stall_o), .sdram_ack(sdram_ack),
    .stb_i(stb_i), .we_i(we_i), .cyc_i(cyc_i), .sel_i(sel_i), .addr_i(addr_i), .data_i(data_i)
  );

  logic [31:0] mem [logic [31:0]];
  logic [31:0] addr_log [$];
  int  dly = 0, wait_cnt = 0, tick = 0, wr_cnt = 0;
  bit  no_ack = 0, stall_en = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a;
  endfunction

  // Slave model: reacts on the falling edge, holds ack while cyc is high
  always @(negedge CLK) begin
    tick++;
    stall_o = stall_en && (tick % 3 == 1);
    if (!cyc_i) begin
      sdram_ack = 1'b0;
      wait_cnt  = 0;
    end else if (!sdram_ack && !no_ack && !stall_o) begin
      if (wait_cnt >= dly) begin
        sdram_ack = 1'b1;
        data_o    = rd(addr_i);
        if (we_i) begin
          mem[addr_i] = data_i;
          wr_cnt++;
        end else begin
          addr_log.push_back(addr_i);
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  int we_viol, stb_viol, we_seen, gap_low, dbl_low, cyc_rise, cyc_run, last_run;
  int pv_cnt, sd_cnt, err_cnt;
  logic prev_cyc = 1'b0, prev_gap = 1'b0;
  logic [PIX_W*K*K-1:0] pv_patch;

  always @(negedge CLK) begin
    #1;
    if (we_i && !cyc_i) we_viol++;
    if (we_i) we_seen++;
    if (stb_i !== (cyc_i && !stall_o)) stb_viol++;
    if (sel_i !== (cyc_i ? 4'hF : 4'h0)) stb_viol++;
    if (busy && !cyc_i) begin
      gap_low++;
      if (prev_gap) dbl_low++;
    end
    prev_gap = busy && !cyc_i;
    if (cyc_i && !prev_cyc) cyc_rise++;
    if (cyc_i) cyc_run++;
    else if (cyc_run > 0) begin
      last_run = cyc_run;
      cyc_run  = 0;
    end
    prev_cyc = cyc_i;
    if (patch_valid) begin
      pv_cnt++;
      pv_patch = patches;
    end
    if (store_done) sd_cnt++;
    if (err) err_cnt++;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input logic [287:0] got, input logic [287:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, got, exp);
    end
  endtask

  task automatic clear_stats();
    we_viol = 0; stb_viol = 0; we_seen = 0; gap_low = 0; dbl_low = 0;
    cyc_rise = 0; cyc_run = 0; last_run = 0; pv_cnt = 0; sd_cnt = 0; err_cnt = 0;
    addr_log.delete();
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    ok = !busy;
    #2;
  endtask

  task automatic run_fetch(input logic [31:0] b, input logic [31:0] s, output bit ok);
    @(negedge CLK);
    base_addr = b; stride = s; start_fetch = 1'b1;
    @(negedge CLK);
    start_fetch = 1'b0;
    wait_idle(ok);
  endtask

  function automatic logic [8:0][31:0] a9(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [8:0][31:0] v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4;
    v[5] = a5; v[6] = a6; v[7] = a7; v[8] = a8;
    return v;
  endfunction

  function automatic logic [PIX_W*K*K-1:0] exp_patch(input logic [8:0][31:0] ad);
    logic [PIX_W*K*K-1:0] p;
    logic [31:0] w;
    for (int i = 0; i < 9; i++) begin
      w = rd(ad[i]);
      p[i*PIX_W +: PIX_W] = w[PIX_W-1:0];
    end
    return p;
  endfunction

  function automatic logic [8:0][31:0] got_addrs();
    logic [8:0][31:0] g = '0;
    for (int i = 0; i < addr_log.size() && i < 9; i++) g[i] = addr_log[i];
    return g;
  endfunction

  typedef struct {
    logic [31:0]      base;
    logic [31:0]      stride;
    int               dly;
    bit               stall;
    logic [8:0][31:0] addrs;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int wr0, n;
    logic [PIX_W*K*K-1:0] exp_d;
    logic [8:0][31:0] ad40, ad0;

    vecs[0] = '{32'd10, 32'd8, 0, 1'b0, a9(10, 11, 12, 18, 19, 20, 26, 27, 28)};
    vecs[1] = '{32'hFFFF_FFFE, 32'd1, 1, 1'b0,
                a9(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 1, 0, 1, 2)};
    vecs[2] = '{32'd100, 32'hFFFF_FFF0, 2, 1'b1, a9(100, 101, 102, 84, 85, 86, 68, 69, 70)};
    vecs[3] = '{32'd0, 32'd3, 0, 1'b1, a9(0, 1, 2, 3, 4, 5, 6, 7, 8)};
    ad40 = a9(40, 41, 42, 48, 49, 50, 56, 57, 58);
    ad0  = a9(0, 1, 2, 3, 4, 5, 6, 7, 8);

    clear_stats();
    repeat (3) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    #2;
    check("reset_outs", {cyc_i, stb_i, we_i, busy, patch_valid, store_done, err, sel_i, addr_i, data_i}, '0);
    check("reset_patches", patches, '0);

    for (int i = 0; i < 4; i++) begin
      clear_stats();
      dly = vecs[i].dly;
      stall_en = vecs[i].stall;
      run_fetch(vecs[i].base, vecs[i].stride, ok);
      check($sformatf("v%0d_done_in_time", i), ok, 1);
      check($sformatf("v%0d_n_reads", i), addr_log.size(), 9);
      check($sformatf("v%0d_addrs", i), got_addrs(), vecs[i].addrs);
      check($sformatf("v%0d_patches", i), patches, exp_patch(vecs[i].addrs));
      check($sformatf("v%0d_pv_patch", i), pv_patch, exp_patch(vecs[i].addrs));
      check($sformatf("v%0d_pv_cnt", i), pv_cnt, 1);
      check($sformatf("v%0d_gap_cycles", i), {gap_low, dbl_low, cyc_rise}, {32'd9, 32'd0, 32'd9});
      check($sformatf("v%0d_stb_sel", i), stb_viol, 0);
    end
    stall_en = 0;

    clear_stats();
    wr0 = wr_cnt;
    dly = 1;
    @(negedge CLK);
    store_addr = 32'd5; store_data = 32'hDEAD_BEEF; start_store = 1'b1;
    @(negedge CLK);
    start_store = 1'b0;
    wait_idle(ok);
    check("st_done_in_time", ok, 1);
    check("st_mem5", rd(32'd5), 32'hDEAD_BEEF);
    check("st_writes", wr_cnt - wr0, 1);
    check("st_pulses", {sd_cnt, pv_cnt, err_cnt}, {32'd1, 32'd0, 32'd0});
    check("st_we_only_in_cyc", we_viol, 0);
    check("st_we_seen", we_seen != 0, 1);
    check("st_gap", gap_low, 1);

    clear_stats();
    wr0 = wr_cnt;
    dly = 0;
    @(negedge CLK);
    base_addr = 32'd40; stride = 32'd8; store_addr = 32'd7; store_data = 32'h1234;
    start_fetch = 1'b1; start_store = 1'b1;
    @(negedge CLK);
    start_fetch = 1'b0; start_store = 1'b0;
    repeat (4) @(negedge CLK);
    start_store = 1'b1;
    @(negedge CLK);
    start_store = 1'b0;
    wait_idle(ok);
    exp_d = exp_patch(ad40);
    check("both_done_in_time", ok, 1);
    check("both_no_write", {wr_cnt - wr0, 31'd0, mem.exists(32'd7)}, '0);
    check("both_pulses", {pv_cnt, sd_cnt}, {32'd1, 32'd0});
    check("both_addrs", got_addrs(), ad40);
    check("both_patches", patches, exp_d);

    clear_stats();
    no_ack = 1;
    run_fetch(32'd0, 32'd3, ok);
    no_ack = 0;
    check("to_done_in_time", ok, 1);
    check("to_err_cnt", err_cnt, 1);
    check("to_cyc_len", last_run, TO);
    check("to_no_done", {pv_cnt, sd_cnt, cyc_rise}, {32'd0, 32'd0, 32'd1});
    check("to_patches_kept", patches, exp_d);

    clear_stats();
    dly = 2;
    @(negedge CLK);
    base_addr = 32'd0; stride = 32'd3; start_fetch = 1'b1;
    @(negedge CLK);
    start_fetch = 1'b0;
    n = 0;
    while (!(addr_log.size() == 3 && cyc_i) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("rst_reached_4th", addr_log.size() == 3 && cyc_i, 1);
    rst = 1'b1;
    @(negedge CLK);
    check("rst_drops_bus", {cyc_i, stb_i, busy}, 3'b000);
    rst = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    check("rst_no_pulse", {pv_cnt, err_cnt}, '0);
    check("rst_patches_cleared", patches, '0);
    clear_stats();
    dly = 0;
    run_fetch(32'd0, 32'd3, ok);
    check("rst_refetch_done", ok, 1);
    check("rst_refetch_addrs", got_addrs(), ad0);
    check("rst_refetch_patches", patches, exp_patch(ad0));
    check("rst_refetch_pv", pv_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
